// File: rtl/dce_ctrl_pkg.sv
// Shared types and sizing helpers for the DCE clock-gating sequencer.
package dce_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        IDLE = 2'd3
    } dce_state_t;

    localparam int unsigned WAKE_CNT_W = 16;

    // Minimum delay-counter width able to hold max(on_dly, off_idle) - 1.
    function automatic int unsigned cnt_w_min(input int unsigned on_dly,
                                              input int unsigned off_idle);
        int unsigned top;
        int unsigned w;
        top = ((on_dly > off_idle) ? on_dly : off_idle) - 1;
        w   = 1;
        for (int i = 1; i < 32; i++) begin
            if ((top >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dce_gate_ctrl.sv
// Clock-gating sequencer driving the DCE ce input: wakes the gated clock on any
// request, withholds acks until it has settled, and gates it off after an idle run.
module dce_gate_ctrl
    import dce_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned ON_DLY   = 4,
    parameter int unsigned OFF_IDLE = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic                  force_on,
    output logic [N_REQ-1:0]      ack,
    output logic                  ce,
    output logic                  clk_active,
    output logic [WAKE_CNT_W-1:0] wake_cnt
);

    if (CNT_W < cnt_w_min(ON_DLY, OFF_IDLE)) begin : g_cnt_w_check
        $error("CNT_W too small for ON_DLY/OFF_IDLE");
    end

    dce_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ce_q, ce_d;
    logic [N_REQ-1:0]      ack_q, ack_d;
    logic                  active_q, active_d;
    logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic                  any;

    assign any = (|req) | force_on;

    // Next-state, delay counter and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ce_d       = ce_q;
        wake_cnt_d = wake_cnt_q;
        unique case (state_q)
            OFF: begin
                if (any) begin
                    state_d = WAKE;
                    ce_d    = 1'b1;
                    cnt_d   = CNT_W'(ON_DLY - 1);
                    if (wake_cnt_q != {WAKE_CNT_W{1'b1}}) begin
                        wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1);
                    end
                end
            end
            WAKE: begin
                // Never aborted: the settle time always runs to completion.
                if (cnt_q == '0) state_d = ON;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ON: begin
                if (!any) begin
                    state_d = IDLE;
                    cnt_d   = CNT_W'(OFF_IDLE - 1);
                end
            end
            IDLE: begin
                if (any) begin
                    state_d = ON;
                end else if (cnt_q == '0) begin
                    state_d = OFF;
                    ce_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = OFF;
                ce_d    = 1'b0;
            end
        endcase
        ack_d    = req & {N_REQ{state_d == ON}};
        active_d = (state_d == ON) || (state_d == IDLE);
    end

    // State and output registers; reset drops ce asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OFF;
            cnt_q      <= '0;
            ce_q       <= 1'b0;
            ack_q      <= '0;
            active_q   <= 1'b0;
            wake_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ce_q       <= ce_d;
            ack_q      <= ack_d;
            active_q   <= active_d;
            wake_cnt_q <= wake_cnt_d;
        end
    end

    assign ack        = ack_q;
    assign ce         = ce_q;
    assign clk_active = active_q;
    assign wake_cnt   = wake_cnt_q;

endmodule

// File: tb/tb_dce_gate_ctrl.sv
// Self-checking bench for dce_gate_ctrl: directed scenarios plus random request
// bursts, compared every cycle against a run-length reference model.
module tb_dce_gate_ctrl;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned ON_DLY   = 4;
    localparam int unsigned OFF_IDLE = 16;
    localparam int unsigned CNT_W    = 8;

    logic             clk;
    logic             rst_n;
    logic [N_REQ-1:0] req;
    logic             force_on;
    logic [N_REQ-1:0] ack;
    logic             ce;
    logic             clk_active;
    logic [15:0]      wake_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: powered / settled flags, cycles since wake, idle run length.
    bit               m_pow;
    bit               m_set;
    int               m_age;
    int               m_idle;
    logic [N_REQ-1:0] m_ack;
    logic [15:0]      m_wakes;

    dce_gate_ctrl #(
        .N_REQ   (N_REQ),
        .ON_DLY  (ON_DLY),
        .OFF_IDLE(OFF_IDLE),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .force_on  (force_on),
        .ack       (ack),
        .ce        (ce),
        .clk_active(clk_active),
        .wake_cnt  (wake_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pow   = 0;
        m_set   = 0;
        m_age   = 0;
        m_idle  = 0;
        m_ack   = '0;
        m_wakes = 16'h0000;
    endtask

    // One sampled edge of the reference behaviour.
    task automatic model_step(input logic [N_REQ-1:0] r, input logic f);
        bit a;
        a = (|r) | f;
        if (!m_pow) begin
            if (a) begin
                m_pow = 1;
                m_age = 0;
                if (m_wakes != 16'hffff) m_wakes = m_wakes + 16'd1;
            end
        end else if (!m_set) begin
            m_age++;
            if (m_age == int'(ON_DLY)) begin
                m_set  = 1;
                m_idle = 0;
            end
        end else begin
            if (a) m_idle = 0;
            else   m_idle++;
            if (m_idle > int'(OFF_IDLE)) begin
                m_pow = 0;
                m_set = 0;
            end
        end
        m_ack = (m_set && m_idle == 0) ? r : '0;
    endtask

    task automatic compare_all();
        check("ce", 16'(ce), 16'(m_pow));
        check("ack", 16'(ack), 16'(m_ack));
        check("clk_active", 16'(clk_active), 16'(m_set));
        check("wake_cnt", wake_cnt, m_wakes);
    endtask

    task automatic cycle(input logic [N_REQ-1:0] r, input logic f);
        req      = r;
        force_on = f;
        @(posedge clk);
        model_step(r, f);
        #1;
        compare_all();
    endtask

    task automatic run(input logic [N_REQ-1:0] r, input logic f, input int n);
        for (int i = 0; i < n; i++) cycle(r, f);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_ce", 16'(ce), 16'h0);
        check("rst_ack", 16'(ack), 16'h0);
        check("rst_clk_active", 16'(clk_active), 16'h0);
        check("rst_wake_cnt", wake_cnt, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N_REQ-1:0] r;
        logic             f;
        int               n;

        rst_n    = 1'b1;
        req      = '0;
        force_on = 1'b0;
        model_reset();
        #2;
        do_reset();
        run(4'b0000, 1'b0, 3);

        // Wake, join, leave, idle-off.
        run(4'b0001, 1'b0, 8);
        run(4'b0011, 1'b0, 3);
        run(4'b0010, 1'b0, 3);
        run(4'b0000, 1'b0, 20);

        // Re-request in IDLE with 5 cycles left.
        run(4'b0001, 1'b0, 8);
        run(4'b0000, 1'b0, 12);
        run(4'b0100, 1'b0, 5);
        run(4'b0000, 1'b0, 20);

        // Simultaneous hand-over between clients.
        run(4'b0001, 1'b0, 8);
        run(4'b1000, 1'b0, 3);
        run(4'b0000, 1'b0, 20);

        // force_on alone keeps the clock running without acks.
        run(4'b0000, 1'b1, 110);
        run(4'b0000, 1'b0, 20);

        // Reset mid-WAKE, then mid-ON.
        run(4'b0001, 1'b0, 2);
        do_reset();
        run(4'b0001, 1'b0, 8);
        do_reset();
        run(4'b0000, 1'b0, 2);

        // Saturated wake counter must not wrap.
        force dut.wake_cnt_q = 16'hffff;
        m_wakes = 16'hffff;
        @(posedge clk);
        #1;
        release dut.wake_cnt_q;
        run(4'b0000, 1'b0, 2);
        run(4'b0010, 1'b0, 8);
        run(4'b0000, 1'b0, 20);
        run(4'b0100, 1'b0, 3);
        run(4'b0000, 1'b0, 20);

        // Random bursts of held requests.
        for (int s = 0; s < 150; s++) begin
            r = N_REQ'($urandom);
            if ($urandom_range(0, 9) < 4) r = '0;
            f = ($urandom_range(0, 9) == 0);
            n = $urandom_range(1, 30);
            run(r, f, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
